// File: rtl/frame_pkg.sv
// Shared frame-path definitions used by the read-side unpackager (and the write-side packager).
package frame_pkg;

  localparam int unsigned FRAME_PIXELS = 76800;
  localparam int unsigned BRAM_DEPTH   = 131072;
  localparam int unsigned ADDR_W       = 24;
  localparam int unsigned PIXEL_W      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StStream
  } unpack_state_t;

  // Fold a one-bit-wider address sum back into [0, depth) with a single compare-and-subtract.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W:0] sum,
                                                  input int unsigned     depth);
    logic [ADDR_W:0] lim;
    logic [ADDR_W:0] res;
    lim = (ADDR_W+1)'(depth);
    res = (sum >= lim) ? (sum - lim) : sum;
    return res[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is on rdata_o whenever empty_o is low.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot a simultaneous push needs, so both are honoured even when full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/frame_unpackager.sv
// Streams one frame out of the frame BRAM: an address beat, then FramePixels pixel beats,
// with the BRAM read latency hidden behind a small FWFT FIFO.
module frame_unpackager
  import frame_pkg::*;
#(
  parameter int unsigned FramePixels = FRAME_PIXELS,
  parameter int unsigned BramDepth   = BRAM_DEPTH,
  parameter int unsigned ReadLatency = 2,
  parameter int unsigned FifoDepth   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  start_addr_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ADDR_W-1:0]  bram_addr_o,
  output logic               bram_en_o,
  input  logic [PIXEL_W-1:0] bram_dout_i,
  output logic               addr_axiov_o,
  output logic [ADDR_W-1:0]  addr_axiod_o,
  output logic               pixel_axiov_o,
  output logic [PIXEL_W-1:0] pixel_axiod_o,
  input  logic               pixel_axiir_i
);

  localparam int unsigned CntW     = $clog2(FramePixels + 1);
  localparam int unsigned FifoCntW = $clog2(FifoDepth + 1);
  localparam int unsigned InflW    = $clog2(ReadLatency + 1);

  unpack_state_t state_q, state_d;

  logic [ADDR_W-1:0]      base_q, base_d;
  logic [CntW-1:0]        issued_q, issued_d;
  logic [CntW-1:0]        sent_q, sent_d;
  logic [ReadLatency-1:0] vld_q, vld_d;
  logic                   done_q, done_d;

  logic                   active, issue, ret, xfer, last_xfer;
  logic                   pixel_valid;
  logic [PIXEL_W-1:0]     pixel_data;
  logic [InflW-1:0]       inflight;
  logic [7:0]             occupancy;
  logic [ADDR_W:0]        addr_sum;

  logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [PIXEL_W-1:0]     fifo_head;
  logic [FifoCntW-1:0]    fifo_cnt;

  sync_fifo #(
    .Width (PIXEL_W),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (bram_dout_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ReadLatency; i++) begin
      inflight = inflight + InflW'(vld_q[i]);
    end
  end

  // Every read in flight has a reserved FIFO slot, so a returning read never finds it full.
  assign occupancy = 8'(fifo_cnt) + 8'(inflight);
  assign active    = (state_q != StIdle);
  assign issue     = active && (issued_q < CntW'(FramePixels)) && (occupancy < 8'(FifoDepth));
  assign ret       = vld_q[ReadLatency-1];
  assign addr_sum  = {1'b0, base_q} + (ADDR_W+1)'(issued_q);

  // Returning data bypasses an empty FIFO so the first pixel appears ReadLatency after its read.
  assign pixel_valid = !fifo_empty || ret;
  assign pixel_data  = fifo_empty ? bram_dout_i : fifo_head;
  assign xfer        = pixel_valid && pixel_axiir_i;
  assign fifo_pop    = !fifo_empty && pixel_axiir_i;
  assign fifo_push   = ret && !(fifo_empty && pixel_axiir_i);
  assign last_xfer   = xfer && (sent_q == CntW'(FramePixels - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StHeader;
      StHeader: state_d = StStream;
      StStream: if (last_xfer) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    base_d   = base_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    vld_d    = (vld_q << 1) | ReadLatency'(issue);
    done_d   = last_xfer;
    if ((state_q == StIdle) && start_i) begin
      base_d   = start_addr_i;
      issued_d = '0;
      sent_d   = '0;
    end
    if (issue) issued_d = issued_q + CntW'(1);
    if (xfer)  sent_d   = sent_q + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q   <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      vld_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      base_q   <= base_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

  // Outputs
  always_comb begin
    busy_o        = active;
    done_o        = done_q;
    bram_en_o     = issue;
    bram_addr_o   = issue ? wrap_addr(addr_sum, BramDepth) : '0;
    addr_axiov_o  = (state_q == StHeader);
    addr_axiod_o  = (state_q == StHeader) ? base_q : '0;
    pixel_axiov_o = pixel_valid;
    pixel_axiod_o = pixel_valid ? pixel_data : '0;
  end

  read_return_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                         !(fifo_push && fifo_full));

endmodule

// File: tb/tb_frame_unpackager.sv
// Directed and randomized bench for frame_unpackager with an 8-pixel frame and a 16-word BRAM.
module tb_frame_unpackager;
  import frame_pkg::*;

  localparam int unsigned FP = 8;
  localparam int unsigned BD = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic               busy, done;
  logic [ADDR_W-1:0]  bram_addr;
  logic               bram_en;
  logic [PIXEL_W-1:0] bram_dout;
  logic               addr_axiov;
  logic [ADDR_W-1:0]  addr_axiod;
  logic               pixel_axiov;
  logic [PIXEL_W-1:0] pixel_axiod;
  logic               pixel_axiir;

  always #5 clk = ~clk;

  frame_unpackager #(
    .FramePixels (FP),
    .BramDepth   (BD),
    .ReadLatency (2),
    .FifoDepth   (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .start_addr_i  (start_addr),
    .busy_o        (busy),
    .done_o        (done),
    .bram_addr_o   (bram_addr),
    .bram_en_o     (bram_en),
    .bram_dout_i   (bram_dout),
    .addr_axiov_o  (addr_axiov),
    .addr_axiod_o  (addr_axiod),
    .pixel_axiov_o (pixel_axiov),
    .pixel_axiod_o (pixel_axiod),
    .pixel_axiir_i (pixel_axiir)
  );

  // Two-cycle BRAM: address in cycle t, data valid throughout cycle t+2.
  logic [7:0] mem [BD];
  logic [7:0] rd1;
  always @(posedge clk) begin
    rd1       <= mem[bram_addr[3:0]];
    bram_dout <= rd1;
  end

  int n_checks, n_pass;
  int cyc, s_cyc;
  int n_en, n_beat, n_done, n_unstable, max_ahead;
  int first_en_cyc, first_pix_cyc, last_pix_cyc, done_cyc, beat_cyc;
  logic              done_busy;
  logic [ADDR_W-1:0] beat_data;
  logic              stall_prev;
  logic [7:0]        stall_data;
  logic [7:0]        got[$];
  logic [23:0]       addr_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    n_en = 0; n_beat = 0; n_done = 0; n_unstable = 0; max_ahead = 0;
    first_en_cyc = -1; first_pix_cyc = -1; last_pix_cyc = -1; done_cyc = -1; beat_cyc = -1;
    done_busy = 1'b1; beat_data = '0; stall_prev = 1'b0; stall_data = '0;
    got.delete();
    addr_log.delete();
  endtask

  // Samples the current cycle at the falling edge, then advances to just after the next rise.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (bram_en) begin
        n_en++;
        addr_log.push_back(bram_addr);
        if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if (addr_axiov) begin
        n_beat++;
        beat_data = addr_axiod;
        beat_cyc  = cyc;
      end
      if (stall_prev && (!pixel_axiov || (pixel_axiod != stall_data))) n_unstable++;
      if (pixel_axiov && pixel_axiir) begin
        got.push_back(pixel_axiod);
        if (first_pix_cyc < 0) first_pix_cyc = cyc;
        last_pix_cyc = cyc;
      end
      stall_prev = pixel_axiov && !pixel_axiir;
      stall_data = pixel_axiod;
      if (done) begin
        n_done++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      if ((n_en - got.size()) > max_ahead) max_ahead = n_en - got.size();
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      3:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic start_frame(input int a);
    start       = 1'b1;
    start_addr  = 24'(a);
    pixel_axiir = 1'b1;
    s_cyc       = cyc;
    tick();
    start       = 1'b0;
  endtask

  task automatic drain(input int mode);
    int guard;
    guard = 0;
    while ((got.size() < FP) && (guard < 400)) begin
      pixel_axiir = ready_for(mode, cyc);
      tick();
      guard++;
    end
  endtask

  // The cycle after the last transfer is the done cycle; optionally start the next frame in it.
  task automatic finish_frame(input bit chain, input int ca);
    pixel_axiir = 1'b1;
    if (chain) begin
      start      = 1'b1;
      start_addr = 24'(ca);
    end
    tick();
    start = 1'b0;
    if (!chain) repeat (2) tick();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},        32'(busy),        0);
    check({tag, "_done"},        32'(done),        0);
    check({tag, "_bram_en"},     32'(bram_en),     0);
    check({tag, "_bram_addr"},   32'(bram_addr),   0);
    check({tag, "_addr_axiov"},  32'(addr_axiov),  0);
    check({tag, "_addr_axiod"},  32'(addr_axiod),  0);
    check({tag, "_pixel_axiov"}, 32'(pixel_axiov), 0);
    check({tag, "_pixel_axiod"}, 32'(pixel_axiod), 0);
  endtask

  // Reference: pixel k of a frame at base a is mem[(a+k) mod BD], read from address (a+k) mod BD.
  task automatic check_frame(input int a, input int mode);
    check("beat_count", 32'(n_beat), 1);
    check("beat_data", 32'(beat_data), 32'(a));
    check("beat_cycle", 32'(beat_cyc), 32'(s_cyc + 1));
    check("pixel_count", 32'(got.size()), FP);
    for (int k = 0; k < FP; k++) begin
      if (k < got.size()) check($sformatf("pixel%0d", k), 32'(got[k]), 32'(mem[(a + k) % BD]));
    end
    check("read_count", 32'(n_en), FP);
    for (int k = 0; k < FP; k++) begin
      if (k < addr_log.size()) check($sformatf("bram_addr%0d", k), 32'(addr_log[k]),
                                     32'((a + k) % BD));
    end
    check("done_count", 32'(n_done), 1);
    check("done_cycle", 32'(done_cyc), 32'(last_pix_cyc + 1));
    check("busy_in_done", 32'(done_busy), 0);
    check("reads_ahead_le4", 32'(max_ahead <= 4), 1);
    check("stall_stability", 32'(n_unstable), 0);
    if (mode == 0) begin
      check("first_read_cycle", 32'(first_en_cyc), 32'(s_cyc + 1));
      check("first_pixel_latency", 32'(first_pix_cyc - first_en_cyc), 2);
      check("back_to_back", 32'(last_pix_cyc - first_pix_cyc), FP - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int guard;
    n_checks = 0; n_pass = 0; cyc = 0; s_cyc = 0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; pixel_axiir = 1'b0;
    for (int i = 0; i < BD; i++) mem[i] = 8'(8'h10 + i);
    clear_logs();

    repeat (3) tick();
    rst_n = 1'b1;
    check_idle_zero("reset");

    // Basic frame, always ready
    clear_logs(); start_frame(0); drain(0); finish_frame(0, 0); check_frame(0, 0);

    // Ready toggling 1,0,0,1
    clear_logs(); start_frame(0); drain(1); finish_frame(0, 0); check_frame(0, 1);

    // Address wrap at the top of the BRAM
    clear_logs(); start_frame(13); drain(0); finish_frame(0, 0); check_frame(13, 0);

    // Second start mid-stream is ignored
    clear_logs(); start_frame(2);
    repeat (3) begin pixel_axiir = 1'b1; tick(); end
    start = 1'b1; start_addr = 24'd7; tick(); start = 1'b0;
    drain(0); finish_frame(0, 0); check_frame(2, 0);

    // Reset after three transfers aborts the frame
    clear_logs(); start_frame(4);
    guard = 0;
    while ((got.size() < 3) && (guard < 100)) begin pixel_axiir = 1'b1; tick(); guard++; end
    check("abort_pre_count", 32'(got.size()), 3);
    pixel_axiir = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_idle_zero("abort");
    clear_logs(); pixel_axiir = 1'b1; repeat (12) tick();
    check("abort_no_done", 32'(n_done), 0);
    check("abort_no_pixels", 32'(got.size()), 0);
    check("abort_no_reads", 32'(n_en), 0);
    clear_logs(); start_frame(5); drain(0); finish_frame(0, 0); check_frame(5, 0);

    // Downstream stalled: FIFO fills to four and reads stop
    clear_logs(); start_frame(9);
    repeat (20) begin pixel_axiir = 1'b0; tick(); end
    check("stall_reads", 32'(n_en), 4);
    check("stall_pixels", 32'(got.size()), 0);
    check("stall_valid", 32'(pixel_axiov), 1);
    check("stall_bram_en", 32'(bram_en), 0);
    check("stall_busy", 32'(busy), 1);
    check("stall_head", 32'(pixel_axiod), 32'(mem[9]));
    drain(0); finish_frame(0, 0); check_frame(9, 2);

    // Start accepted in the done cycle
    clear_logs(); start_frame(1); drain(0); finish_frame(1, 11); check_frame(1, 0);
    clear_logs(); s_cyc = cyc - 1; drain(0); finish_frame(0, 0); check_frame(11, 0);

    // Random contents, base address and ready pattern
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < BD; i++) mem[i] = 8'($urandom);
      a = int'($urandom_range(0, BD - 1));
      clear_logs(); start_frame(a); drain(3); finish_frame(0, 0); check_frame(a, 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
